setpoint_adjust: RTL
====================

// Module: setpoint_adjust
// PURPOSE
//  Converts the two debounced push-button levels (UP/DOWN, from debounce stages) into a
//  saturating patient-temperature setpoint with tap-to-step and hold-to-auto-repeat.
//  Sits directly downstream of the debounce blocks and feeds the temperature controller/display.
//  Setpoint unit is 0.1 degC; sp_changed strobes on every actual value change.
// PARAMETERS
//  SP_W          10          setpoint width (bits, unsigned)
//  SP_MIN        300         lower limit (30.0 C)
//  SP_MAX        400         upper limit (40.0 C)
//  SP_DEFAULT    370         value loaded at reset (37.0 C)
//  STEP          5           increment/decrement per step (0.5 C)
//  HOLD_CYCLES   50_000_000  cycles a button is held before auto-repeat starts (0.5 s @100 MHz)
//  REPEAT_CYCLES 10_000_000  cycles between auto-repeat steps (0.1 s @100 MHz)
// PORTS
//  clk         in   1     system clock, 100 MHz
//  reset_n     in   1     asynchronous reset, active-low
//  btn_up      in   1     debounced UP button level (1 = pressed)
//  btn_down    in   1     debounced DOWN button level (1 = pressed)
//  setpoint    out  SP_W  current setpoint, registered
//  sp_changed  out  1     one-cycle pulse: setpoint changed on this edge
//  at_limit    out  1     setpoint == SP_MIN or SP_MAX (combinational from setpoint)
// BEHAVIOUR
//  Reset (async assert, sync release): setpoint=SP_DEFAULT, sp_changed=0, cnt=0, state=LOCK.
//  FSM states: IDLE, HOLD, REPEAT, LOCK. dir register latches UP/DOWN on leaving IDLE.
//  LOCK : no steps; both buttons low -> IDLE. (Button held through reset never steps.)
//  IDLE : exactly one button high -> apply one step in that dir, cnt=0, -> HOLD.
//         both high same cycle -> LOCK, no step. both low -> stay.
//  HOLD : active button low -> IDLE (cnt cleared). other button high -> LOCK.
//         else cnt++; on cnt==HOLD_CYCLES-1 -> step, cnt=0, -> REPEAT.
//  REPEAT: same release/LOCK rules as HOLD; on cnt==REPEAT_CYCLES-1 -> step, cnt=0.
//  Release and LOCK checks take priority over the count-terminal step in the same cycle.
//  Latency: step applied on the edge that samples the press; new setpoint and sp_changed
//   visible the cycle after btn first sampled high. Held 1+HOLD_CYCLES cycles -> 2nd step.
//  Step arithmetic in SP_W+1 bits: UP = min(sp+STEP, SP_MAX); DOWN = max(sp-STEP, SP_MIN)
//   (no wrap; sp-STEP below 0 clamps to SP_MIN).
//  sp_changed=1 only if new value != old; step attempts at a limit leave sp_changed=0,
//   FSM keeps counting normally.
//  cnt width = clog2(max(HOLD_CYCLES,REPEAT_CYCLES)); counter saturates never (always reset
//   on terminal). Reset mid-operation: immediate return to reset values, no pulse.
//  Requires SP_MIN <= SP_DEFAULT <= SP_MAX, STEP >= 1, HOLD/REPEAT_CYCLES >= 2.
// TESTING  (bench params: HOLD_CYCLES=20, REPEAT_CYCLES=5, others default)
//  1 Reset with btn_up held, release reset, keep up 30 cyc then release -> setpoint stays 370,
//    no sp_changed; subsequent tap then works.
//  2 Tap up 3 cyc -> setpoint 375, exactly one sp_changed pulse; at_limit=0.
//  3 Hold up 36 consecutive cyc -> steps at press, +20, +25, +30, +35 -> setpoint 395,
//    5 pulses.
//  4 Hold down for 400 cyc from 370 -> reaches 300 and stops; at_limit=1; no pulses after
//    reaching 300; also tap up at 400 -> stays 400, no pulse.
//  5 Hold up, press down mid-HOLD -> no further steps until both released; press both same
//    cycle from IDLE -> no change.
//  6 Assert reset_n=0 asynchronously mid-REPEAT at 390 -> setpoint 370 immediately,
//    sp_changed=0, state LOCK.

Source files
------------

// File: rtl/setpoint_adjust.sv
// Button-driven saturating setpoint with tap-to-step and hold-to-auto-repeat.
// A button level present when the block comes out of reset is ignored until both buttons are released.
module setpoint_adjust #(
  parameter int SP_W          = 10,
  parameter int SP_MIN        = 300,
  parameter int SP_MAX        = 400,
  parameter int SP_DEFAULT    = 370,
  parameter int STEP          = 5,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            btn_up,
  input  logic            btn_down,
  output logic [SP_W-1:0] setpoint,
  output logic            sp_changed,
  output logic            at_limit
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HOLD_T   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_T = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [SP_W:0]    MIN_X    = (SP_W+1)'(SP_MIN);
  localparam logic [SP_W:0]    MAX_X    = (SP_W+1)'(SP_MAX);
  localparam logic [SP_W:0]    STEP_X   = (SP_W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;        // 1 = UP
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             chg_q, chg_d;

  logic             do_step, step_up;
  logic             act_btn, oth_btn;
  logic [SP_W:0]    sp_x, up_sum, dn_diff, new_x;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    step_up = dir_q;
    act_btn = dir_q ? btn_up : btn_down;
    oth_btn = dir_q ? btn_down : btn_up;

    unique case (state_q)
      IDLE: begin
        if (btn_up ^ btn_down) begin
          do_step = 1'b1;
          step_up = btn_up;
          dir_d   = btn_up;
          cnt_d   = '0;
          state_d = HOLD;
        end else if (btn_up && btn_down) begin
          state_d = LOCK;
        end
      end
      HOLD, REPEAT: begin
        // Release and lockout win over a terminal count landing on the same edge.
        if (!act_btn) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (oth_btn) begin
          cnt_d   = '0;
          state_d = LOCK;
        end else if (cnt_q == ((state_q == HOLD) ? HOLD_T : REPEAT_T)) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCK: begin
        cnt_d = '0;
        if (!btn_up && !btn_down) state_d = IDLE;
      end
      default: state_d = LOCK;
    endcase
  end

  // One extra bit keeps the sum from wrapping before the clamp.
  always_comb begin
    sp_x    = {1'b0, sp_q};
    up_sum  = sp_x + STEP_X;
    dn_diff = sp_x - STEP_X;
    if (step_up) new_x = (up_sum > MAX_X) ? MAX_X : up_sum;
    else         new_x = (sp_x < STEP_X || dn_diff < MIN_X) ? MIN_X : dn_diff;
    sp_d  = sp_q;
    chg_d = 1'b0;
    if (do_step) begin
      sp_d  = new_x[SP_W-1:0];
      chg_d = (new_x[SP_W-1:0] != sp_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOCK;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sp_q    <= SP_W'(SP_DEFAULT);
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
      chg_q   <= chg_d;
    end
  end

  assign setpoint   = sp_q;
  assign sp_changed = chg_q;
  assign at_limit   = (sp_q == SP_W'(SP_MIN)) || (sp_q == SP_W'(SP_MAX));

endmodule
